// File: rtl/arbiter8_rr.sv
// -----------------------------------------------------------------------------
// arbiter8_rr -- 8-way round-robin arbiter with hold-until-release grants.
//
// A two-state FSM (IDLE, GRANT) and a 3-bit round-robin pointer.
// In IDLE, the first active request at or above the pointer wins, wrapping
// 7 -> 0. The grant is presented one edge later and held until either:
//   - the grantee signals iRelease, or
//   - the grantee drops its request.
// The following edge clears the grant and moves the pointer past the grantee.
// A release edge never also arbitrates, so there is always at least one IDLE
// cycle between grants.
//
// Optional feature (macro ARB_TIMEOUT_EN):
//   An 8-bit grant-length counter forces a release after TIMEOUT grant cycles
//   and pulses oTimeout in the cycle the outputs clear. Without the macro the
//   counter is absent, oTimeout is constant 0 and grants are held
//   indefinitely.
//
// Parameters:
//   TIMEOUT    maximum grant length in cycles, legal range 2..255
//
// Ports:
//   iClk       clock, rising edge
//   iRst       asynchronous active-high reset
//   iReq[7:0]  request lines, one per requester
//   iRelease   current grantee is finished (only looked at in GRANT)
//   oGrant     registered one-hot grant, or all zero
//   oIdx       binary index of the grantee, 0 when idle
//   oValid     high whenever oGrant is non-zero
//   oTimeout   one-cycle pulse on a forced release
// -----------------------------------------------------------------------------
module arbiter8_rr #(
    parameter int TIMEOUT = 16
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic [7:0] iReq,
    input  logic       iRelease,
    output logic [7:0] oGrant,
    output logic [2:0] oIdx,
    output logic       oValid,
    output logic       oTimeout
);

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("arbiter8_rr: TIMEOUT must be in 2..255");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [7:0] grant_q, grant_d;
    logic [2:0] idx_q, idx_d;
    logic       valid_q, valid_d;

    // Rotate the requests so that bit 0 is the requester at ptr.
    // The lowest set bit of the rotated vector is then the winner's
    // offset from ptr.
    logic [15:0] req_dbl;
    logic [7:0]  req_rot;
    logic [2:0]  win_off;
    logic [2:0]  win_idx;
    logic [7:0]  win_onehot;

    assign req_dbl = {iReq, iReq};
    assign req_rot = req_dbl[ptr_q +: 8];

    always_comb begin
        win_off = 3'd0;
        // Scan downward so that the lowest set bit is the last assignment.
        for (int i = 7; i >= 0; i--) begin
            if (req_rot[i]) begin
                win_off = 3'(i);
            end
        end
    end

    // 3-bit addition wraps naturally modulo 8.
    assign win_idx    = ptr_q + win_off;
    assign win_onehot = 8'b1 << win_idx;

    // Voluntary release: explicit release, or the grantee dropped its request.
    logic release_req;
    assign release_req = iRelease | ~iReq[idx_q];

    // Forced release from the grant-length counter (always 0 when disabled).
    logic cnt_expired;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       timeout_q, timeout_d;

    assign cnt_expired = (state_q == GRANT) && (cnt_q == CNT_LAST);

    always_comb begin
        // The counter sits at zero while idle, so it starts from zero on
        // entry to GRANT and counts completed grant cycles from there.
        cnt_d     = 8'd0;
        timeout_d = 1'b0;
        if (state_q == GRANT) begin
            cnt_d = cnt_q + 8'd1;
            // A voluntary release wins over a coincident timeout.
            timeout_d = cnt_expired & ~release_req;
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            cnt_q     <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign oTimeout = timeout_q;
`else
    assign cnt_expired = 1'b0;
    assign oTimeout    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        unique case (state_q)
            IDLE: begin
                if (iReq != 8'd0) begin
                    state_d = GRANT;
                    grant_d = win_onehot;
                    idx_d   = win_idx;
                    valid_d = 1'b1;
                end
            end
            GRANT: begin
                if (release_req || cnt_expired) begin
                    state_d = IDLE;
                    ptr_d   = idx_q + 3'd1;
                    grant_d = 8'd0;
                    idx_d   = 3'd0;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q <= IDLE;
            ptr_q   <= 3'd0;
            grant_q <= 8'd0;
            idx_q   <= 3'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
        end
    end

    assign oGrant = grant_q;
    assign oIdx   = idx_q;
    assign oValid = valid_q;

endmodule

// File: tb/tb_arbiter8_rr.sv
// -----------------------------------------------------------------------------
// tb_arbiter8_rr -- directed self-checking bench for arbiter8_rr.
//
// The DUT is built with TIMEOUT=4. With ARB_TIMEOUT_EN defined, the forced
// release path is checked. Otherwise the bench checks that the grant is held
// with oTimeout low. Inputs change 1 ns after the rising edge, and outputs
// are sampled at the same point.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_arbiter8_rr;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       rel;
    logic [7:0] grant;
    logic [2:0] idx;
    logic       valid;
    logic       tmo;

    int n_checks = 0;
    int n_fail   = 0;

    arbiter8_rr #(
        .TIMEOUT(4)
    ) dut (
        .iClk    (clk),
        .iRst    (rst),
        .iReq    (req),
        .iRelease(rel),
        .oGrant  (grant),
        .oIdx    (idx),
        .oValid  (valid),
        .oTimeout(tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One line per transaction; the three grant outputs are checked together.
    task automatic check_out(input string tag, input logic [7:0] eg, input logic [2:0] ei,
                             input logic ev);
        $display("[%0t] %s req=%02h rel=%0b -> grant=%02h idx=%0d valid=%0b tmo=%0b",
                 $time, tag, req, rel, grant, idx, valid, tmo);
        check_eq({tag, ".grant"}, 32'(grant), 32'(eg));
        check_eq({tag, ".idx"},   32'(idx),   32'(ei));
        check_eq({tag, ".valid"}, 32'(valid), 32'(ev));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        req = 8'h00;
        rel = 1'b0;
        #3;
        check_out("reset", 8'h00, 3'd0, 1'b0);
        check_eq("reset.tmo", 32'(tmo), 32'd0);
        tick();
        tick();
        rst = 1'b0;

        // Basic grant, then release, then the next requester above the pointer.
        req = 8'h05;
        tick(); check_out("basic_d0", 8'h01, 3'd0, 1'b1);
        rel = 1'b1;
        tick(); check_out("basic_rel", 8'h00, 3'd0, 1'b0);
        rel = 1'b0;
        tick(); check_out("basic_d2", 8'h04, 3'd2, 1'b1);

        // Grantee drops its request; the pointer moves to 3 and D6 wins.
        req = 8'h40;
        tick(); check_out("drop_d2", 8'h00, 3'd0, 1'b0);
        tick(); check_out("grant_d6", 8'h40, 3'd6, 1'b1);
        req = 8'h00;
        tick(); check_out("drop_d6", 8'h00, 3'd0, 1'b0);
        rel = 1'b1;
        tick(); check_out("idle_rel_ignored", 8'h00, 3'd0, 1'b0);
        rel = 1'b0;

        // Pointer is 7: D7 wins over D0, the grant holds, and the pointer wraps to 0.
        req = 8'h81;
        tick(); check_out("wrap_d7", 8'h80, 3'd7, 1'b1);
        req = 8'hFF;
        tick(); check_out("hold_d7", 8'h80, 3'd7, 1'b1);
        rel = 1'b1;
        tick(); check_out("wrap_rel", 8'h00, 3'd0, 1'b0);
        rel = 1'b0;
        req = 8'h81;
        tick(); check_out("wrap_d0", 8'h01, 3'd0, 1'b1);

        // D3 drops its request without iRelease; the pointer becomes 4.
        req = 8'h08;
        tick(); check_out("drop_d0", 8'h00, 3'd0, 1'b0);
        tick(); check_out("grant_d3", 8'h08, 3'd3, 1'b1);
        req = 8'h00;
        tick(); check_out("drop_d3", 8'h00, 3'd0, 1'b0);
        req = 8'hFF;
        tick(); check_out("ptr4_d4", 8'h10, 3'd4, 1'b1);

        // A release with requests pending is handled before the next arbitration.
        rel = 1'b1;
        tick(); check_out("rel_first", 8'h00, 3'd0, 1'b0);
        rel = 1'b0;
        tick(); check_out("grant_d5", 8'h20, 3'd5, 1'b1);

        // An asynchronous reset mid-grant clears the outputs before the next edge.
        #2 rst = 1'b1;
        #1 check_out("async_rst", 8'h00, 3'd0, 1'b0);
        #1 rst = 1'b0;
        tick(); check_out("post_rst_d0", 8'h01, 3'd0, 1'b1);

        // Grant-length behaviour on D2.
        rel = 1'b1;
        tick(); check_out("pre_tmo_rel", 8'h00, 3'd0, 1'b0);
        rel = 1'b0;
        req = 8'h04;
        tick(); check_out("tmo_c0", 8'h04, 3'd2, 1'b1);
        for (int k = 1; k < 4; k++) begin
            tick(); check_out($sformatf("tmo_c%0d", k), 8'h04, 3'd2, 1'b1);
            check_eq($sformatf("tmo_c%0d.tmo", k), 32'(tmo), 32'd0);
        end
        tick();
`ifdef ARB_TIMEOUT_EN
        check_out("tmo_force", 8'h00, 3'd0, 1'b0);
        check_eq("tmo_force.tmo", 32'(tmo), 32'd1);
        req = 8'h0C;
        tick(); check_out("tmo_ptr3_d3", 8'h08, 3'd3, 1'b1);
        check_eq("tmo_pulse_end", 32'(tmo), 32'd0);
        for (int k = 1; k < 4; k++) begin
            tick(); check_out($sformatf("tmo2_c%0d", k), 8'h08, 3'd3, 1'b1);
        end
        // The counter expires in the same cycle as a voluntary release.
        rel = 1'b1;
        tick(); check_out("tmo_vs_rel", 8'h00, 3'd0, 1'b0);
        check_eq("tmo_vs_rel.tmo", 32'(tmo), 32'd0);
        rel = 1'b0;
`else
        check_out("no_tmo_hold", 8'h04, 3'd2, 1'b1);
        check_eq("no_tmo_hold.tmo", 32'(tmo), 32'd0);
        req = 8'h0C;
        tick(); check_out("no_tmo_hold2", 8'h04, 3'd2, 1'b1);
        check_eq("no_tmo_hold2.tmo", 32'(tmo), 32'd0);
        rel = 1'b1;
        tick(); check_out("no_tmo_rel", 8'h00, 3'd0, 1'b0);
        rel = 1'b0;
`endif

        // Full rotation with all requests active.
        req = 8'hFF;
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        for (int k = 0; k < 9; k++) begin
            logic [7:0] exp_g;
            exp_g = 8'h01 << (k % 8);
            tick(); check_out($sformatf("rr_%0d", k), exp_g, 3'(k % 8), 1'b1);
            rel = 1'b1;
            tick(); check_out($sformatf("rr_gap_%0d", k), 8'h00, 3'd0, 1'b0);
            rel = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/arbiter8_rr.md
ARBITER8_RR -- requirements
Module: arbiter8_rr

Interface
REQ-001 Parameter TIMEOUT, default 16, sets the maximum grant length in cycles (legal 2..255) and is used only when ARB_TIMEOUT_EN is defined.
REQ-002 Port iClk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 Port iRst, input, 1: reset, asynchronous, active-high.
REQ-004 Port iReq, input, 8: request lines D7..D0, active-high, one per requester.
REQ-005 Port iRelease, input, 1: the current grantee finishes; sampled only in GRANT.
REQ-006 Port oGrant, output, 8: registered one-hot grant, or all zero.
REQ-007 Port oIdx, output, 3: binary index of the granted requester (D0->000 ... D7->111), 000 when no grant.
REQ-008 Port oValid, output, 1: high exactly when oGrant is non-zero.
REQ-009 Port oTimeout, output, 1: one-cycle pulse on a forced release.

Function
REQ-010 The block SHALL implement a two-state FSM (IDLE, GRANT) plus a 3-bit round-robin pointer ptr.
REQ-011 In IDLE with iReq == 0, the FSM SHALL stay in IDLE and all outputs SHALL stay 0.
REQ-012 In IDLE with iReq != 0, the winner SHALL be the first set bit found searching upward from ptr, wrapping 7->0.
REQ-013 The winner SHALL appear on oGrant/oIdx/oValid on the clock edge after the request is sampled (latency 1 cycle), and the FSM SHALL enter GRANT.
REQ-014 In GRANT, oGrant, oIdx and oValid SHALL hold constant regardless of other iReq bits.
REQ-015 In GRANT, a release SHALL occur on the cycle iRelease == 1 or iReq[oIdx] == 0.
REQ-016 On release, the next edge SHALL clear all outputs, set ptr to oIdx+1 mod 8 (111 wraps to 000), and return the FSM to IDLE.
REQ-017 Release and new arbitration SHALL NOT overlap; there is always at least one IDLE cycle between grants.
REQ-018 If iRelease and new requests arrive in the same cycle, the release SHALL be processed first, and arbitration SHALL occur in the following IDLE cycle using the updated ptr.
REQ-019 iRelease SHALL be ignored in IDLE.
REQ-020 oGrant SHALL always equal the one-hot decode of oIdx when oValid is 1.

Reset
REQ-021 Asserting iRst SHALL immediately (without waiting for a clock) set FSM=IDLE, ptr=000, oGrant=0, oIdx=000, oValid=0, oTimeout=0, and clear the timeout counter.
REQ-022 Reset asserted during GRANT SHALL drop the grant immediately.
REQ-023 The first arbitration after reset SHALL start its search from D0.

Configuration
REQ-024 Macro ARB_TIMEOUT_EN, when defined, SHALL add an 8-bit counter that clears on GRANT entry and increments each GRANT cycle.
REQ-025 With ARB_TIMEOUT_EN defined, when the counter reaches TIMEOUT-1 and no release has occurred, the block SHALL force a release with the same behaviour as REQ-016 and pulse oTimeout high for the cycle in which outputs clear.
REQ-026 With ARB_TIMEOUT_EN defined, a normal release and a timeout in the same cycle SHALL count as a normal release, with oTimeout=0.
REQ-027 Without ARB_TIMEOUT_EN, the counter SHALL not exist, oTimeout SHALL be tied to 0, and a grant SHALL be held indefinitely.

Verification
REQ-028 Reset then iReq=8'b00000101 -> one cycle later oGrant=00000001, oIdx=000, oValid=1; iRelease pulse -> outputs 0; next cycle oGrant=00000100, oIdx=010.
REQ-029 Wrap-around: grant D7 (iReq=8'b10000001 with ptr=111) then release -> ptr=000; next grant is D0, oIdx=000.
REQ-030 Drop during grant: D3 granted, iReq[3] falls to 0 with iRelease=0 -> release next edge, ptr=100.
REQ-031 Reset mid-grant: D5 granted, iRst pulses between clock edges -> oGrant=0 and oValid=0 before the next edge; the next grant with iReq=8'hFF is D0.
REQ-032 ARB_TIMEOUT_EN defined, TIMEOUT=4: D2 held with no release -> grant lasts 4 cycles, then oTimeout=1 for 1 cycle, oGrant=0, ptr=011.
REQ-033 iReq=8'hFF held and iRelease pulsed once per grant -> grant order D0,D1,...,D7,D0, each grant separated by exactly one idle cycle.
